// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver that tracks the currently held key (make/break/E0 aware).
// Latency: about 2 sync + FILTER_LEN filter cycles from the pin edge to the sample; outputs register 1 Clk after the stop-bit sample.
// Backpressure: none; key_strobe/frame_err are one-cycle pulses. Define PS2_TIMEOUT_EN to enable the mid-frame timeout.
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // synchroniser and filter state
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_hit, sample;

  // frame state
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          start_en, shift_en, par_en, stop_en;
  logic          frame_good, frame_bad, timeout;

  // key tracking state
  logic [7:0]    keycode_q, keycode_d;
  logic          ext_q, ext_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;

  // two-flop synchronisers for both pins; idle bus level is high
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DAT;
      dat_s2_q <= dat_s1_q;
    end
  end

  // glitch filter: follow the synced clock only after FILTER_LEN consecutive differing cycles
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    filt_hit   = (clk_s2_q != filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
    if (clk_s2_q != filt_q) begin
      if (filt_hit) filt_d = clk_s2_q;
      else          filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  // a falling transition of the filtered clock is the bit sample event
  assign sample = filt_hit && filt_q;

  // filter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // stall counter: any sample event or a return to IDLE restarts it
  always_comb begin
    timeout  = (state_q != S_IDLE) && !sample && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    to_cnt_d = to_cnt_q + TW'(1);
    if ((state_q == S_IDLE) || sample || timeout) to_cnt_d = '0;
  end

  // stall counter register
  always_ff @(posedge Clk) begin
    if (Reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  // TIMEOUT_CYC only matters when the timeout is compiled in
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a timeout abort takes precedence (it never coincides with a sample)
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (sample) begin
      case (state_q)
        S_IDLE:   if (!dat_s2_q) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: datapath enables qualified by the sample event
  always_comb begin
    start_en = sample && (state_q == S_IDLE) && !dat_s2_q;
    shift_en = sample && (state_q == S_DATA);
    par_en   = sample && (state_q == S_PARITY);
    stop_en  = sample && (state_q == S_STOP);
  end

  // odd parity over data+parity and a high stop bit make a good byte
  assign frame_good = stop_en && dat_s2_q && (^{shift_q, parity_q});
  assign frame_bad  = stop_en && !frame_good;

  // shift register, bit counter and parity capture (LSB arrives first)
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    if (timeout) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end
    if (start_en) bit_cnt_d = '0;
    if (shift_en) begin
      shift_d   = {dat_s2_q, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (par_en) parity_d = dat_s2_q;
  end

  // datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
    end
  end

  // byte interpretation: prefixes arm flags, make/break update the held key
  always_comb begin
    keycode_d  = keycode_q;
    ext_d      = ext_q;
    strobe_d   = 1'b0;
    err_d      = frame_bad || timeout;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    if (frame_good) begin
      if (shift_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        if (brk_pend_q) begin
          // only the release of the key being held clears the output
          if ((shift_q == keycode_q) && (ext_pend_q == ext_q)) begin
            keycode_d = 8'h00;
            ext_d     = 1'b0;
            strobe_d  = 1'b1;
          end
        end else if ({ext_pend_q, shift_q} != {ext_q, keycode_q}) begin
          // typematic repeats of the held key fall through silently
          keycode_d = shift_q;
          ext_d     = ext_pend_q;
          strobe_d  = 1'b1;
        end
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  // key tracking registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode_q  <= 8'h00;
      ext_q      <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      keycode_q  <= keycode_d;
      ext_q      <= ext_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  assign keycode    = keycode_q;
  assign extended   = ext_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;

endmodule
